// File: rtl/m_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the data memory (slave).
interface m_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/m_stage.sv
// Memory stage: issues ILW/ISW on a variable-latency req/ack bus, stalls upstream while waiting,
// and loads the Memory->Writeback register. Optional misalignment trap: M_STAGE_ALIGN_CHECK_EN.
module m_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  M_op,
    input  logic [31:0] M_valE,
    input  logic [31:0] M_valA,
    input  logic [4:0]  M_dstE,
    input  logic [4:0]  M_dstM,
    m_stage_if.master   dmem,
    output logic [5:0]  W_op,
    output logic [31:0] W_valE,
    output logic [31:0] W_valM,
    output logic [4:0]  W_dstE,
    output logic [4:0]  W_dstM,
    output logic        m_stall,
    output logic        m_err
);
    localparam logic [5:0] ILW = 6'b100011;
    localparam logic [5:0] ISW = 6'b101011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    state_t state_nxt;
    logic   is_mem;
    logic   misalign;
    logic   start;
    logic   w_take;
    logic   stall_c;

    assign is_mem = (M_op == ILW) || (M_op == ISW);

`ifdef M_STAGE_ALIGN_CHECK_EN
    assign misalign = is_mem && (M_valE[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A misaligned access falls through both branches in IDLE, so W takes a bubble.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        start     = 1'b0;
        w_take    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem && !misalign) begin
                    stall_c   = 1'b1;
                    start     = 1'b1;
                    state_nxt = BUSY;
                end else if (!is_mem) begin
                    w_take = 1'b1;
                end
            end
            BUSY: begin
                if (dmem.dmem_ack) begin
                    w_take    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_stall = stall_c & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W_op   <= '0;
            W_valE <= '0;
            W_valM <= '0;
            W_dstE <= '0;
            W_dstM <= '0;
        end else if (w_take) begin
            W_op   <= M_op;
            W_valE <= M_valE;
            W_valM <= (state == BUSY && M_op == ILW) ? dmem.dmem_rdata : 32'd0;
            W_dstE <= M_dstE;
            W_dstM <= M_dstM;
        end else begin
            W_op   <= '0;
            W_valE <= '0;
            W_valM <= '0;
            W_dstE <= '0;
            W_dstM <= '0;
        end
    end

    // addr/wdata hold their last values between accesses; only req qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
        end else if (start) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= (M_op == ISW);
            dmem.dmem_addr  <= M_valE;
            dmem.dmem_wdata <= M_valA;
        end else if (state == BUSY && dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
        end
    end

`ifdef M_STAGE_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_err <= 1'b0;
        else     m_err <= (state == IDLE) && misalign;
    end
`else
    assign m_err = 1'b0;
`endif
endmodule

// File: tb/tb_m_stage.sv
// Bench for m_stage: table of per-cycle vectors through a scoreboard queue, plus reset sequences.
module tb_m_stage;
    localparam logic [5:0] ILW   = 6'b100011;
    localparam logic [5:0] ISW   = 6'b101011;
    localparam logic [5:0] IADDI = 6'b001000;
    localparam logic [5:0] IORI  = 6'b001101;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  M_op;
    logic [31:0] M_valE, M_valA;
    logic [4:0]  M_dstE, M_dstM;
    logic [5:0]  W_op;
    logic [31:0] W_valE, W_valM;
    logic [4:0]  W_dstE, W_dstM;
    logic        m_stall, m_err;

    m_stage_if bus();

    m_stage dut (
        .clk(clk), .rst(rst),
        .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .dmem(bus),
        .W_op(W_op), .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .m_stall(m_stall), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;    logic [31:0] valE;  logic [31:0] valA;
        logic [4:0]  dstE;  logic [4:0]  dstM;  logic        ack;   logic [31:0] rdata;
        logic        stall; logic        req;   logic        we;
        logic [31:0] addr;  logic [31:0] wdata; logic        err;
        logic [5:0]  wop;   logic [31:0] wvalE; logic [31:0] wvalM;
        logic [4:0]  wdstE; logic [4:0]  wdstM;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check combinational stall, then compare registered results.
    task automatic step(input vec_t v);
        vec_t e;
        M_op = v.op; M_valE = v.valE; M_valA = v.valA; M_dstE = v.dstE; M_dstM = v.dstM;
        bus.dmem_ack = v.ack; bus.dmem_rdata = v.rdata;
        #3;
        chk("m_stall", {31'd0, m_stall}, {31'd0, v.stall});
        sb.push_back(v);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("dmem_req",   {31'd0, bus.dmem_req}, {31'd0, e.req});
        chk("dmem_we",    {31'd0, bus.dmem_we},  {31'd0, e.we});
        chk("dmem_addr",  bus.dmem_addr,  e.addr);
        chk("dmem_wdata", bus.dmem_wdata, e.wdata);
        chk("m_err",      {31'd0, m_err}, {31'd0, e.err});
        chk("W_op",       {26'd0, W_op},   {26'd0, e.wop});
        chk("W_valE",     W_valE, e.wvalE);
        chk("W_valM",     W_valM, e.wvalM);
        chk("W_dstE",     {27'd0, W_dstE}, {27'd0, e.wdstE});
        chk("W_dstM",     {27'd0, W_dstM}, {27'd0, e.wdstM});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op    valE          valA        dE     dM     ack   rdata         stl   req   we    addr          wdata       err   wop   wvalE         wvalM         wdE    wdM
        tbl[0]  = '{IADDI, 32'h3,        32'h0,      5'd3,  5'd0,  1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,      1'b0, IADDI, 32'h3,        32'h0,        5'd3,  5'd0};
        tbl[1]  = '{ILW,   32'h10,       32'h55,     5'd0,  5'd5,  1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10,       32'h55,     1'b0, 6'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        tbl[2]  = '{ILW,   32'h10,       32'h55,     5'd0,  5'd5,  1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10,       32'h55,     1'b0, 6'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        tbl[3]  = '{ILW,   32'h10,       32'h55,     5'd0,  5'd5,  1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10,       32'h55,     1'b0, 6'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        tbl[4]  = '{ILW,   32'h10,       32'h55,     5'd0,  5'd5,  1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h10,       32'h55,     1'b0, ILW,   32'h10,       32'hDEADBEEF, 5'd0,  5'd5};
        tbl[5]  = '{IORI,  32'h7,        32'h0,      5'd9,  5'd0,  1'b1, 32'hFFFF,     1'b0, 1'b0, 1'b0, 32'h10,       32'h55,     1'b0, IORI,  32'h7,        32'h0,        5'd9,  5'd0};
        tbl[6]  = '{ISW,   32'h20,       32'h1234,   5'd1,  5'd2,  1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h20,       32'h1234,   1'b0, 6'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        tbl[7]  = '{ISW,   32'h20,       32'h1234,   5'd1,  5'd2,  1'b1, 32'hABCD,     1'b0, 1'b0, 1'b0, 32'h20,       32'h1234,   1'b0, ISW,   32'h20,       32'h0,        5'd1,  5'd2};
        tbl[8]  = '{ILW,   32'hFFFFFFFC, 32'h0,      5'd0,  5'd31, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,      1'b0, 6'd0,  32'h0,        32'h0,        5'd0,  5'd0};
        tbl[9]  = '{ILW,   32'hFFFFFFFC, 32'h0,      5'd0,  5'd31, 1'b1, 32'h80000001, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,      1'b0, ILW,   32'hFFFFFFFC, 32'h80000001, 5'd0,  5'd31};
        tbl[10] = '{IADDI, 32'hFFFFFFFF, 32'h0,      5'd31, 5'd31, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,      1'b0, IADDI, 32'hFFFFFFFF, 32'h0,        5'd31, 5'd31};

        // Reset held with a load presented: no stall, no request, W cleared.
        rst = 1'b1;
        M_op = ILW; M_valE = 32'h10; M_valA = 32'h0; M_dstE = 5'd0; M_dstM = 5'd5;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        #3;
        chk("rst_stall", {31'd0, m_stall}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stall2", {31'd0, m_stall}, 32'd0);
        chk("rst_req",    {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_addr",   bus.dmem_addr, 32'd0);
        chk("rst_W_op",   {26'd0, W_op}, 32'd0);
        chk("rst_W_valE", W_valE, 32'd0);
        chk("rst_m_err",  {31'd0, m_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) step(tbl[i]);

        // Misaligned load.
`ifdef M_STAGE_ALIGN_CHECK_EN
        step('{ILW, 32'h13, 32'h0, 5'd0, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0});
        step('{6'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0});
`else
        step('{ILW, 32'h13, 32'h0, 5'd0, 5'd7, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0});
        step('{ILW, 32'h13, 32'h0, 5'd0, 5'd7, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 1'b0, ILW, 32'h13, 32'h77, 5'd0, 5'd7});
`endif

        // Reset pulsed mid-cycle while BUSY: request drops without an edge; a late ack is ignored.
        step('{ILW, 32'h40, 32'h5, 5'd0, 5'd3, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h5, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0});
        #2;
        rst = 1'b1;
        M_op = 6'd0; M_valE = 32'h0; M_valA = 32'h0; M_dstE = 5'd0; M_dstM = 5'd0;
        #1;
        chk("busy_rst_req",   {31'd0, bus.dmem_req}, 32'd0);
        chk("busy_rst_stall", {31'd0, m_stall}, 32'd0);
        chk("busy_rst_addr",  bus.dmem_addr, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        step('{6'd0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'd0, 32'h0, 32'h0, 5'd0, 5'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_stage.md
# m_stage

Memory stage of the 5-stage pipeline: consumes the instruction held in the Execute→Memory pipeline register (the M_* fields), performs the data-memory access for `ILW`/`ISW` over a variable-latency req/ack bus, and loads the Memory→Writeback register (W_* outputs). While an access is outstanding it raises `m_stall` so the upstream pipeline registers hold their contents.

## Interface
- No parameters. Opcode values come from the shared opcode header: `ILW` = 6'b100011, `ISW` = 6'b101011.
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- M_op  in  6  opcode of instruction in M
- M_valE  in  32  ALU result; effective address for `ILW`/`ISW`
- M_valA  in  32  store data for `ISW`
- M_dstE  in  5  ALU-result destination register
- M_dstM  in  5  load destination register
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write (`ISW`), 0 = read (`ILW`)
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; rdata valid this cycle for reads
- dmem_rdata  in  32  load data
- W_op, W_valE, W_valM, W_dstE, W_dstM  out  6/32/32/5/5  Memory→Writeback register
- m_stall  out  1  hold upstream registers this cycle, combinational
- m_err  out  1  misaligned-access flag, registered; tied 0 unless `M_STAGE_ALIGN_CHECK_EN` is defined

## Operation
- FSM states: IDLE, BUSY. Reset state: IDLE.
- IDLE, M_op not `ILW`/`ISW`:
  - next edge loads W_op/W_valE/W_dstE/W_dstM from M_*; W_valM = 0.
  - m_stall = 0.
- IDLE, M_op is `ILW`/`ISW`:
  - m_stall = 1.
  - next edge captures dmem_addr = M_valE, dmem_wdata = M_valA, dmem_we = (M_op == `ISW`), dmem_req = 1, and goes to BUSY.
  - W loads a bubble: all W_* = 0.
- BUSY, dmem_ack = 0:
  - m_stall = 1; dmem_* held stable; W loads a bubble.
- BUSY, dmem_ack = 1:
  - m_stall = 0.
  - next edge loads W from M_*, with W_valM = dmem_rdata for `ILW` and 0 for `ISW`.
  - dmem_req and dmem_we clear; state returns to IDLE.
- Upstream holds M_* constant while m_stall = 1, so the M_* values sampled on the ack cycle are those of the original instruction.
- dmem_ack in IDLE: ignored.
- dmem_addr and dmem_wdata retain their last values when idle; only dmem_req qualifies them.

## Timing
- Non-memory op: W updated 1 edge after the op presents in M; 0 stall cycles.
- Memory op with ack in the first BUSY cycle: W updated 2 edges after presentation; 1 stall cycle.
- Each additional ack-wait cycle adds 1 stall cycle and 1 W bubble.
- dmem_req rises the edge after presentation; falls the edge after ack.
- Reset values: every W_* = 0; dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0; m_err = 0; state = IDLE.
- m_stall is forced 0 while rst = 1.
- Reset during BUSY clears dmem_req immediately (asynchronous). The in-flight access is abandoned; an ack arriving after rst is released is ignored.

## Configuration
- `M_STAGE_ALIGN_CHECK_EN` defined, `ILW`/`ISW` with M_valE[1:0] != 0:
  - no bus access, no stall, no BUSY entry.
  - W loads a bubble.
  - m_err = 1 for exactly the cycle following the edge.
- Undefined: no alignment check. The access proceeds with the full address, and m_err is constant 0.

## Test plan
- Reset: rst = 1 with M_op = `ILW` → m_stall = 0, dmem_req = 0, all W_* = 0; after release, the pipeline resumes from IDLE.
- `IADDI` with M_valE = 3, M_dstE = 3 → next edge W_op = `IADDI`, W_valE = 3, W_dstE = 3, W_valM = 0; m_stall stays 0.
- `ILW` with M_valE = 0x10, M_dstM = 5, ack on the third BUSY cycle with dmem_rdata = 0xDEADBEEF:
  - m_stall high 3 cycles; dmem_addr = 0x10, dmem_we = 0 for 3 cycles.
  - W shows bubbles, then W_valM = 0xDEADBEEF, W_dstM = 5.
- `ISW` with M_valE = 0x20, M_valA = 0x1234, ack in the first BUSY cycle → dmem_req high 1 cycle with dmem_we = 1, dmem_wdata = 0x1234; m_stall high 1 cycle; W_op = `ISW`, W_valM = 0.
- rst pulsed while BUSY → dmem_req drops without waiting for an edge; a dmem_ack one cycle after release produces no W update and no stall.
- `ILW` with M_valE = 0x13:
  - with `M_STAGE_ALIGN_CHECK_EN`: dmem_req stays 0, m_err = 1 for one cycle, W is a bubble.
  - without it: dmem_req asserts with dmem_addr = 0x13.
